// File: rtl/stream_rd_pkg.sv
// Shared constants for the RAM stream reader and its skid FIFO.
package stream_rd_pkg;

    // Reader FSM encoding
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    // Output buffer depth; the issue rule keeps buffered + in-flight words within this
    localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO with flush; head is always the oldest entry.
module skid_fifo2
    import stream_rd_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    localparam logic [1:0] Full = 2'(FifoDepth);

    logic [W-1:0] mem_q [FifoDepth];
    logic [W-1:0] mem_d [FifoDepth];
    logic         wr_q, wr_d, rd_q, rd_d;
    logic [1:0]   count_q, count_d;
    logic         push_en, pop_en;

    // Next-state for storage, pointers and occupancy; flush drops all entries
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        pop_en  = pop && (count_q != 2'd0);
        push_en = push && ((count_q != Full) || pop_en);
        if (flush) begin
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push_en) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (pop_en) begin
                rd_d = rd_q + 1'b1;
            end
            count_d = count_q + {1'b0, push_en} - {1'b0, pop_en};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/ram_stream_reader.sv
// Reads len words from a registered-read RAM starting at start_addr and presents
// them as a valid/ready stream. Define STREAM_RD_LOOP_EN to replay the pass
// continuously until abort or reset.
module ram_stream_reader
    import stream_rd_pkg::*;
#(
    parameter int unsigned D  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned LW = D + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic [LW-1:0] len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          ram_re,
    output logic [D-1:0]  ram_addr,
    input  logic [W-1:0]  ram_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last
);

    logic [1:0]    state_q, state_d;
    logic [D-1:0]  addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          inflight_q, inflight_d;
    logic          inflight_last_q, inflight_last_d;
    logic          done_q, done_d;
`ifdef STREAM_RD_LOOP_EN
    logic [D-1:0]  base_q, base_d;
    logic [LW-1:0] len_q, len_d;
`endif

    logic [1:0]    fifo_count;
    logic [W:0]    fifo_head;
    logic          pop, issue_ok, last_issue;

    assign out_valid  = (fifo_count != 2'd0);
    assign pop        = out_valid && out_ready;
    assign last_issue = (rem_q == LW'(1));
    // Room for one more word once this cycle's pop is accounted for
    assign issue_ok   = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign ram_re     = (state_q == StRun) && !abort && issue_ok;

    // FSM, address/remaining counters and read-pipeline tracking
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        done_d          = 1'b0;
        inflight_d      = ram_re;
        inflight_last_d = ram_re && last_issue;
`ifdef STREAM_RD_LOOP_EN
        base_d          = base_q;
        len_d           = len_q;
`endif
        // A start in IDLE takes precedence over a simultaneous abort
        if (abort && !((state_q == StIdle) && start)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_d = start_addr;
                        rem_d  = len;
`ifdef STREAM_RD_LOOP_EN
                        base_d = start_addr;
                        len_d  = len;
`endif
                        if (len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    if (ram_re) begin
                        addr_d = addr_q + D'(1);
                        rem_d  = rem_q - LW'(1);
                        if (last_issue) begin
`ifdef STREAM_RD_LOOP_EN
                            addr_d = base_q;
                            rem_d  = len_q;
`else
                            state_d = StDrain;
`endif
                        end
                    end
                end
                StDrain: begin
                    if (pop && fifo_head[W]) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
`ifdef STREAM_RD_LOOP_EN
            base_q          <= '0;
            len_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
`ifdef STREAM_RD_LOOP_EN
            base_q          <= base_d;
            len_q           <= len_d;
`endif
        end
    end

    // Returning RAM word lands in the FIFO tagged with its last flag
    skid_fifo2 #(
        .W (W + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q && !abort),
        .push_data ({inflight_last_q, ram_rdata}),
        .pop       (pop),
        .flush     (abort),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign ram_addr = addr_q;
    assign out_data = fifo_head[W-1:0];
    assign out_last = out_valid && fifo_head[W];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader against a registered-read RAM model and a
// queue-based reference of the expected address and word sequences.
module tb_ram_stream_reader;

    localparam int D  = 4;
    localparam int W  = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          reset, start, abort, out_ready;
    logic [D-1:0]  start_addr;
    logic [LW-1:0] len;
    logic          busy, done, ram_re, out_valid, out_last;
    logic [D-1:0]  ram_addr;
    logic [W-1:0]  ram_rdata, out_data;

    always #5 clk = ~clk;

    ram_stream_reader #(.D(D), .W(W), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .ram_re     (ram_re),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    // Scratch RAM: registered read, data held while re is low, RAM[i] = i + 0x10
    logic [W-1:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
    initial ram_rdata = '0;
    always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int         exp_addr [$];
    logic [8:0] exp_word [$];
    int         issued, accepted;
    logic       stall_q;
    logic [8:0] held;
    int         cyc, first_re, first_valid, hs_first, hs_last, done_cnt, done_cyc;
    logic       busy_seen;

    task automatic clear_tracking();
        exp_addr.delete();
        exp_word.delete();
        issued = 0; accepted = 0; stall_q = 1'b0;
        first_re = -1; first_valid = -1; hs_first = -1; hs_last = -1;
        done_cnt = 0; done_cyc = -1; busy_seen = 1'b0;
    endtask

    task automatic expect_pass(input int addr, input int n);
        for (int k = 0; k < n; k++) begin
            logic [8:0] w;
            w = {(k == n - 1), 8'(((addr + k) % 16) + 16)};
            exp_addr.push_back((addr + k) % 16);
            exp_word.push_back(w);
        end
    endtask

    // Per-cycle observation, called once the cycle's inputs are settled
    task automatic sample();
        if (stall_q) begin
            check_eq("stall_valid", 32'(out_valid), 1);
            check_eq("stall_data", {23'd0, out_last, out_data}, {23'd0, held});
        end
        if (ram_re) begin
            check_eq("re_expected", 32'(exp_addr.size() > 0), 1);
            if (exp_addr.size() > 0) check_eq("ram_addr", 32'(ram_addr), exp_addr.pop_front());
            issued++;
            if (first_re < 0) first_re = cyc;
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            check_eq("beat_expected", 32'(exp_word.size() > 0), 1);
            if (exp_word.size() > 0)
                check_eq("beat", {23'd0, out_last, out_data}, {23'd0, exp_word.pop_front()});
            accepted++;
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
        end
        check_eq("buffered_le2", 32'((issued - accepted) <= 2), 1);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_seen = 1'b1;
        stall_q = out_valid && !out_ready;
        held    = {out_last, out_data};
    endtask

    task automatic step(input int pct, input logic ab, input logic st);
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 99) < pct);
        abort     = ab;
        start     = st;
        #1;
        cyc++;
        sample();
    endtask

    task automatic run_xfer(input int addr, input int n, input int pct);
        clear_tracking();
        expect_pass(addr, n);
        start_addr = 4'(addr);
        len        = 5'(n);
        cyc = -1;
        step(pct, 1'b0, 1'b1);
        while (cyc < 300 && !(done_cnt > 0 && cyc >= done_cyc + 2)) step(pct, 1'b0, 1'b0);
        check_eq("done_once", 32'(done_cnt), 1);
        check_eq("words_left", 32'(exp_word.size()), 0);
        check_eq("reads_left", 32'(exp_addr.size()), 0);
        check_eq("busy_idle", 32'(busy), 0);
        check_eq("busy_seen", 32'(busy_seen), 32'(n != 0));
        check_eq("done_cycle", 32'(done_cyc), (n == 0) ? 32'd1 : 32'(hs_last + 1));
    endtask

    // Abort in the given RUN cycle, then confirm a silent return to idle
    task automatic run_abort(input int addr, input int n, input int pct, input int ab_cyc);
        clear_tracking();
        expect_pass(addr, n);
        start_addr = 4'(addr);
        len        = 5'(n);
        cyc = -1;
        step(pct, 1'b0, 1'b1);
        for (int c = 1; c < ab_cyc; c++) step(pct, 1'b0, 1'b0);
        step(pct, 1'b1, 1'b0);
        check_eq("abort_re_low", 32'(ram_re), 0);
        clear_tracking();
        step(100, 1'b0, 1'b0);
        check_eq("abort_valid", 32'(out_valid), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
        repeat (4) step(100, 1'b0, 1'b0);
        check_eq("abort_no_done", 32'(done_cnt), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start_addr = '0; len = '0; cyc = 0;
        clear_tracking();
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_re", 32'(ram_re), 0);
        check_eq("rst_addr", 32'(ram_addr), 0);
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_data", 32'(out_data), 0);
        check_eq("rst_last", 32'(out_last), 0);
        reset = 1'b0;

`ifdef STREAM_RD_LOOP_EN
        run_xfer(5, 0, 100);
        clear_tracking();
        for (int r = 0; r < 14; r++) expect_pass(2, 3);
        start_addr = 4'd2;
        len        = 5'd3;
        cyc = -1;
        step(100, 1'b0, 1'b1);
        while (cyc < 200 && accepted < 15) step(70, 1'b0, 1'b0);
        check_eq("loop_words", 32'(accepted >= 15), 1);
        check_eq("loop_no_done", 32'(done_cnt), 0);
        check_eq("loop_busy", 32'(busy), 1);
        step(100, 1'b1, 1'b0);
        clear_tracking();
        step(100, 1'b0, 1'b0);
        check_eq("loop_abort_busy", 32'(busy), 0);
        check_eq("loop_abort_valid", 32'(out_valid), 0);
        repeat (4) step(100, 1'b0, 1'b0);
`else
        // Basic pass with latency and throughput checks
        run_xfer(3, 5, 100);
        check_eq("lat_re", 32'(first_re), 1);
        check_eq("lat_valid", 32'(first_valid), 3);
        check_eq("throughput", 32'(hs_last - hs_first), 4);
        // Address wrap-around
        run_xfer(14, 4, 100);
        // Random backpressure
        run_xfer($urandom_range(0, 15), 8, 50);
        // Zero length
        run_xfer(5, 0, 100);
        // Abort in the third RUN cycle while stalled, then a fresh pass
        run_abort(4, 8, 0, 3);
        run_xfer(0, 2, 100);
        // Abort while a read would otherwise issue
        run_abort(9, 6, 100, 2);
        // Random passes including full-depth length
        repeat (5) run_xfer($urandom_range(0, 15), $urandom_range(1, 16), $urandom_range(30, 100));
        run_xfer(7, 16, 60);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
